// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampled UART byte receiver with false-start rejection, 3-sample
// majority voting and framing checks. Define UART_RX_PARITY_EN for 8E1 frames with parity_err.
module uart_rx_os16 #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int DIV      = CLK_FREQ / (BAUD * 16)
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int DW = $clog2(DIV);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic          rx_s1, rx_s2, rx_s3;
    logic [1:0]    fill;
    logic          armed;
    logic [DW-1:0] div_cnt;
    logic [3:0]    s_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          v7, v8;
    logic          tick, decide, maj, fall;

    assign tick   = (div_cnt == DW'(DIV - 1));
    assign decide = tick && (s_cnt == 4'd9);
    assign maj    = (v7 & v8) | (v7 & rx_s2) | (v8 & rx_s2);
    assign fall   = armed & rx_s3 & ~rx_s2;

    // NOTE: synchroniser flops reset to 1 so reset release never looks like a falling edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // Edges count only once the synchroniser holds real line data and that line was seen high,
    // so a line already low at reset release is not taken as a start bit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            fill <= {fill[0], 1'b1};
            if (fill[1] && rx_s2)
                armed <= 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;
`endif

    // NOTE: non-blocking assignments make every register update from pre-edge values, so a
    // later assignment in this block simply overrides an earlier default for the same cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            s_cnt     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            v7        <= 1'b0;
            v8        <= 1'b0;
            po_data   <= '0;
            po_flag   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            po_flag   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick) begin
                s_cnt <= s_cnt + 4'd1;
                if (s_cnt == 4'd7) v7 <= rx_s2;
                if (s_cnt == 4'd8) v8 <= rx_s2;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= START;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                        s_cnt   <= '0;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    if (decide) begin
                        if (maj) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shreg   <= {maj, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (decide) begin
                        par_bad <= maj ^ (^shreg);
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Leave at the count-9 decision so a back-to-back start edge is not missed.
                    if (decide) begin
                        if (!maj) begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                            s_cnt     <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end else begin
                                po_data <= shreg;
                                po_flag <= 1'b1;
                            end
`else
                            po_data <= shreg;
                            po_flag <= 1'b1;
`endif
                        end
                    end
                end
                BREAK: begin
                    // s_cnt counts consecutive high ticks here.
                    if (tick) begin
                        if (!rx_s2) begin
                            s_cnt <= '0;
                        end else if (s_cnt == 4'd15) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: table vectors, hand-written corner sequences and
// randomized jittered frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_os16;
    localparam int CLK_FREQ = 1_536_000;
    localparam int BAUD     = 9600;
    localparam int BIT      = 160;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int NV     = 6;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int NV     = 4;
`endif

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rx        = 1'b1;
    logic [7:0] po_data;
    logic       po_flag, frame_err, parity_err, busy;

    uart_rx_os16 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx        (rx),
        .po_data   (po_data),
        .po_flag   (po_flag),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         n_flag = 0, n_ferr = 0, n_perr = 0, width_bad = 0;
    logic       prev_flag = 1'b0;

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (po_flag) begin
                got_q.push_back(po_data);
                n_flag++;
            end
            if (frame_err) n_ferr++;
            if (parity_err) n_perr++;
            if ((po_flag && prev_flag) || (po_flag && (frame_err || parity_err)))
                width_bad++;
        end
        prev_flag = po_flag;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic set_rx(input logic v, input int cycles);
        rx = v;
        wait_clk(cycles);
    endtask

    // Each bit edge lands within +/-jit clocks of its nominal time; the frame length is exact.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int jit);
        logic bits[$];
        int   jp, jn;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (PAR_EN) bits.push_back(par);
        bits.push_back(stop);
        jp = 0;
        foreach (bits[i]) begin
            if (i == bits.size() - 1 || jit == 0) jn = 0;
            else jn = int'($urandom_range(2 * jit)) - jit;
            set_rx(bits[i], BIT + jn - jp);
            jp = jn;
        end
    endtask

    // Frame outcome from the line rules: 0 = good byte, 1 = framing error, 2 = parity error.
    function automatic int model(input logic [7:0] d, input logic stop, input logic par);
        if (!stop) return 1;
        if (PAR_EN && (par != ^d)) return 2;
        return 0;
    endfunction

    task automatic compare_bytes(input string name);
        logic [31:0] g;
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF;
            check({name, "_byte"}, g, exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        bit         par_ok;
        bit         exp_flag;
        bit         exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        int f0, e0, p0, r, gap, exp_ferr, exp_perr;
        logic [7:0] d;
        logic stp, par;

        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55};
        vecs[1] = '{8'hA3, 1'b1, 1'b1, 1'b0, 8'hA3};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
`ifdef UART_RX_PARITY_EN
        vecs[4] = '{8'h07, 1'b1, 1'b1, 1'b0, 8'h07};
        vecs[5] = '{8'h07, 1'b0, 1'b0, 1'b1, 8'h07};
`endif

        wait_clk(5);
        check("rst_po_data", po_data, 8'h00);
        check("rst_po_flag", po_flag, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        sys_rst_n = 1'b1;
        wait_clk(BIT);

        for (int v = 0; v < NV; v++) begin
            f0 = n_flag; p0 = n_perr;
            send_frame(vecs[v].data, 1'b1,
                       vecs[v].par_ok ? ^vecs[v].data : ~^vecs[v].data, 0);
            wait_clk(BIT / 4);
            check($sformatf("vec%0d_flag", v), n_flag - f0, vecs[v].exp_flag);
            check($sformatf("vec%0d_perr", v), n_perr - p0, vecs[v].exp_perr);
            check($sformatf("vec%0d_data", v), po_data, vecs[v].exp_data);
            check($sformatf("vec%0d_busy", v), busy, 1'b0);
            got_q.delete();
        end

        // Short low glitch: busy after exactly 3 clocks, then a rejected false start.
        f0 = n_flag; e0 = n_ferr;
        rx = 1'b0;
        @(posedge sys_clk); @(posedge sys_clk); #1;
        check("busy_lat2", busy, 1'b0);
        @(posedge sys_clk); #1;
        check("busy_lat3", busy, 1'b1);
        @(negedge sys_clk);
        wait_clk(37);
        set_rx(1'b1, BIT - 40);
        check("glitch_busy", busy, 1'b0);
        check("glitch_flag", n_flag - f0, 0);
        check("glitch_ferr", n_ferr - e0, 0);

        // Bad stop bit followed by a held break, then recovery.
        f0 = n_flag; e0 = n_ferr;
        send_frame(8'h3C, 1'b0, ^8'h3C, 0);
        set_rx(1'b0, 3 * BIT);
        check("brk_ferr", n_ferr - e0, 1);
        check("brk_flag", n_flag - f0, 0);
        check("brk_busy", busy, 1'b1);
        set_rx(1'b1, 2 * BIT);
        check("brk_exit_busy", busy, 1'b0);
        send_frame(8'h81, 1'b1, ^8'h81, 0);
        wait_clk(BIT / 4);
        check("brk_rec_flag", n_flag - f0, 1);
        check("brk_rec_data", po_data, 8'h81);
        check("brk_ferr_once", n_ferr - e0, 1);
        got_q.delete();

        // Back-to-back frames with zero idle bits and jittered edges.
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send_frame(8'h12, 1'b1, ^8'h12, 15);
        send_frame(8'h34, 1'b1, ^8'h34, 15);
        wait_clk(BIT / 4);
        compare_bytes("b2b");

        // Reset during bit 4 of 0xFF.
        set_rx(1'b0, BIT);
        set_rx(1'b1, 4 * BIT + BIT / 2);
        check("pre_rst_busy", busy, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_po_data", po_data, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_flag", po_flag, 1'b0);
        check("mid_rst_ferr", frame_err, 1'b0);
        wait_clk(3 * BIT);
        sys_rst_n = 1'b1;
        wait_clk(BIT);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, ^8'h7E, 0);
        wait_clk(BIT / 4);
        compare_bytes("post_rst");

        // Line already low when reset is released.
        e0 = n_ferr;
        rx = 1'b0;
        sys_rst_n = 1'b0;
        wait_clk(5);
        sys_rst_n = 1'b1;
        wait_clk(2 * BIT);
        check("low_rel_busy", busy, 1'b0);
        check("low_rel_ferr", n_ferr - e0, 0);
        set_rx(1'b1, 2 * BIT);

        // Randomized frames against the reference model.
        e0 = n_ferr; p0 = n_perr;
        exp_ferr = 0; exp_perr = 0;
        got_q.delete();
        for (int k = 0; k < 24; k++) begin
            d   = 8'($urandom);
            stp = ($urandom_range(7) != 0);
            par = ($urandom_range(7) == 0) ? ~^d : ^d;
            r   = model(d, stp, par);
            if (r == 0) exp_q.push_back(d);
            else if (r == 1) exp_ferr++;
            else exp_perr++;
            send_frame(d, stp, par, 15);
            gap = stp ? int'($urandom_range(BIT)) : 2 * BIT + int'($urandom_range(BIT));
            set_rx(1'b1, gap);
        end
        wait_clk(BIT);
        compare_bytes("rand");
        check("rand_ferr", n_ferr - e0, exp_ferr);
        check("rand_perr", n_perr - p0, exp_perr);
        check("flag_width", width_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

16x-oversampled UART byte receiver that sits directly upstream of the CPU's instruction loader. It deserialises the `uart_rx_pin` line into bytes and presents each one as `po_data` with a one-cycle `po_flag` strobe. The loader consumes these bytes as the instruction-count header and as instruction LSB/MSB pairs. The block adds input synchronisation, false-start rejection, 3-sample majority voting and framing-error reporting, so a noisy serial line cannot corrupt instruction memory.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency, in Hz.
- `BAUD`, 9600: line bit rate.
- `DIV`, CLK_FREQ/(BAUD*16), truncated: clocks per oversample tick. Must be ≥ 2.

Ports:
- `sys_clk`, input, 1: system clock. The only clock.
- `sys_rst_n`, input, 1: reset, asynchronous, active-low.
- `rx`, input, 1: serial line. Idles high. Frame is 8N1, or 8E1 with the parity option compiled in.
- `po_data`, output, 8: last good byte. Holds its value until the next good byte.
- `po_flag`, output, 1: one-cycle pulse when `po_data` updates.
- `frame_err`, output, 1: one-cycle pulse on a bad stop bit.
- `parity_err`, output, 1: one-cycle pulse on a parity mismatch. Tied 0 when the parity option is compiled out.
- `busy`, output, 1: high from start-bit detection until the receiver returns to IDLE.

## Operation
- Input conditioning: `rx` passes through a 2-flop synchroniser, then a third flop used for falling-edge detection. All decisions use the synchronised value.
- Tick divider: counts 0..DIV-1 and pulses `tick` at DIV-1. It is cleared on start-edge detection so tick phase aligns to the start bit.
- Sample counter: 4 bits, 0..15, advanced per tick. The bit value is the majority of the samples at counts 7, 8 and 9. The decision is taken on the tick at count 9.
- States and transitions:
  - IDLE → START on a falling edge of synchronised `rx`.
  - START: if the majority is 1, it is a false start; go to IDLE with no outputs. Otherwise go to DATA.
  - DATA: 8 bits, LSB first, shifted into an internal shift register. Bit index counts 0..7. After bit 7, go to PARITY if the option is compiled in, otherwise STOP.
  - PARITY: the expected bit is the even parity of the 8 data bits. Latch the mismatch and go to STOP.
  - STOP:
    - Majority 1 and no parity mismatch: load `po_data` and pulse `po_flag`.
    - Majority 1 with a parity mismatch: pulse `parity_err` only.
    - Majority 0: pulse `frame_err` and go to BREAK.
    - In all non-BREAK cases, go to IDLE immediately after the count-9 decision, without waiting out the stop bit. This allows resync on a following start edge.
  - BREAK: wait until synchronised `rx` is 1 for 16 consecutive ticks, then go to IDLE. No bytes are emitted while `rx` is held low.
- `frame_err` and `parity_err` never coincide with `po_flag`.

## Timing
- Reset values:
  - Outputs: `po_data`=0x00, `po_flag`=0, `frame_err`=0, `parity_err`=0, `busy`=0.
  - Internals: state=IDLE; divider, sample counter, bit index and shift register all 0.
  - Synchroniser flops reset to 1, so no false edge occurs at reset release.
- Latency: from the `rx` falling edge at the pin to `busy`=1 is 3 `sys_clk` cycles.
- `po_flag` asserts 1 cycle after the stop-bit count-9 tick, about 9.5 bit times after the start edge plus 3 cycles of synchroniser delay.
- Back-to-back frames with zero idle bits are received without loss. The next start edge arrives at least 6 ticks after the return to IDLE.
- `sys_rst_n` asserted mid-frame aborts immediately to the reset values. After release, the receiver waits in IDLE for a fresh falling edge. A line that is already low at release is not treated as a start.
- There is no backpressure: the consumer must sample `po_data` on `po_flag`. The next byte overwrites it one frame later at the earliest.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined: the frame is 8E1 and the PARITY state is present. `parity_err` is driven, and a byte with wrong parity is dropped (no `po_flag`).
- Undefined: the frame is 8N1, there is no PARITY state, and `parity_err` is a constant 0.

## Test plan
Common bench settings: CLK_FREQ=1_536_000, BAUD=9600, giving DIV=10 and 160 clocks per bit.
- Send 0x55, then 0xA3, each with a good stop bit → `po_data`=0x55, then 0xA3. Each `po_flag` is exactly 1 cycle wide, and `busy` falls after each frame.
- Drive a 40-clock low glitch on idle `rx` → no `po_flag` and no `frame_err`; `busy` pulses and returns to 0 within 1 bit time.
- Send 0x3C with the stop bit forced to 0, then hold `rx` low for 3 bit times → one `frame_err` pulse, no `po_flag`, and the receiver stays in BREAK. Then release `rx` and send 0x81 → `po_flag` with 0x81.
- Send 0x12 and 0x34 back-to-back with zero idle bits, each bit edge jittered ±15 clocks → two `po_flag` pulses carrying 0x12 then 0x34.
- Assert `sys_rst_n`=0 during bit 4 of 0xFF → all outputs return to their reset values. After release, send 0x7E → `po_flag` with 0x7E and no stray byte before it.
- With `UART_RX_PARITY_EN` defined: send 0x07 with parity 1 → `po_flag` with 0x07. Send 0x07 with parity 0 → one `parity_err` pulse, no `po_flag`, and `po_data` still 0x07.
